// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM encoding and widths for the pipeline hazard controller
package pipe_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  typedef enum logic {RUN, DWAIT} state_t;
endpackage

// File: rtl/sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at all-ones instead of wrapping
module sat_cnt16
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  // count one per qualifying cycle, hold once every bit is set
  always_ff @(posedge clk or posedge res)
    if (res) q <= '0;
    else if (inc && q != '1) q <= q + CNT_W'(1);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for data-memory waits, taken branches and load-use hazards
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             pc_sel_branch,
  output logic             dmem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state;
  logic br_pend, acc, mem_stall, br, lu, lu_stall;
  // priority chain: memory wait freezes everything, a taken branch overrides a load-use stall
  always_comb begin
    acc = mem_read | mem_write;
    mem_stall = ~dmem_ready & ((state == DWAIT) | acc);
    br = ~mem_stall & (mem_branch | br_pend);
    lu = ex_mem_read & (ex_rd != '0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    lu_stall = ~mem_stall & ~br & lu;
  end
  assign pc_en = ~res & ~mem_stall & ~lu_stall;
  assign ifid_en = ~res & ~mem_stall & ~lu_stall;
  assign idex_en = ~res & ~mem_stall;
  assign exmem_en = ~res & ~mem_stall;
  assign ifid_flush = ~res & br;
  assign idex_flush = ~res & (br | lu_stall);
  assign exmem_flush = ~res & br;
  assign memwb_bubble = ~res & mem_stall;
  assign pc_sel_branch = ~res & br;
  assign dmem_req = ~res & ((state == DWAIT) | acc);
  // wait state tracks an outstanding access; a branch seen while frozen is remembered until release
  always_ff @(posedge clk or posedge res)
    if (res) begin
      state <= RUN;
      br_pend <= 1'b0;
    end else begin
      state <= mem_stall ? DWAIT : RUN;
      br_pend <= mem_stall & (mem_branch | br_pend);
    end
  sat_cnt16 u_stall (.clk(clk), .res(res), .inc(~res & (mem_stall | lu_stall)), .q(stall_cnt));
  sat_cnt16 u_flush (.clk(clk), .res(res), .inc(~res & br), .q(flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed corner sequences and random run against a behavioural model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, res = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, dmem_ready = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush;
  logic memwb_bubble, pc_sel_branch, dmem_req;
  logic [15:0] stall_cnt, flush_cnt;
  logic [9:0] ctl, cur_ctl;
  int checks = 0, errors = 0;
  bit m_wait, m_pend;
  int m_stall, m_flush;

  typedef struct {
    logic [4:0] rs, rt;
    logic urt, emr;
    logic [4:0] erd;
    logic br, mr, mw, rdy;
    logic [9:0] ctl;
  } vec_t;
  vec_t tab[14];

  pipe_hazard_ctrl dut (
    .clk(clk), .res(res), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch(mem_branch),
    .mem_read(mem_read), .mem_write(mem_write), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .pc_sel_branch(pc_sel_branch), .dmem_req(dmem_req),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush,
                memwb_bubble, pc_sel_branch, dmem_req};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt; ex_mem_read = v.emr; ex_rd = v.erd;
    mem_branch = v.br; mem_read = v.mr; mem_write = v.mw; dmem_ready = v.rdy;
  endtask

  task automatic idle();
    vec_t v;
    v = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    set_in(v);
  endtask

  task automatic model_clear();
    m_wait = 0; m_pend = 0; m_stall = 0; m_flush = 0;
  endtask

  // one clock: compare DUT against the model mid-cycle, then advance the model at the edge
  task automatic cycle();
    logic [9:0] e;
    bit access, sm, b, hz, l, dreq;
    @(negedge clk);
    access = mem_read || mem_write;
    dreq = m_wait || access;
    sm = !dmem_ready && (m_wait || access);
    b = !sm && (mem_branch || m_pend);
    hz = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    l = !sm && !b && hz;
    if (sm) e = 10'b0000_000_1_0_1;
    else if (b) e = {4'b1111, 3'b111, 1'b0, 1'b1, dreq};
    else if (l) e = {4'b0011, 3'b010, 1'b0, 1'b0, dreq};
    else e = {4'b1111, 3'b000, 1'b0, 1'b0, dreq};
    cur_ctl = ctl;
    chk("ctl", ctl, e);
    chk("stall_cnt", stall_cnt, 16'(m_stall));
    chk("flush_cnt", flush_cnt, 16'(m_flush));
    @(posedge clk);
    if (sm) m_pend = m_pend || mem_branch;
    else m_pend = 0;
    m_wait = sm;
    if ((sm || l) && m_stall < 65535) m_stall++;
    if (b && m_flush < 65535) m_flush++;
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    idle();
    @(posedge clk);
    #1 res = 1'b0;
    model_clear();
  endtask

  initial begin
    tab[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1111_000_0_0_0};
    tab[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0011_010_0_0_0};
    tab[2]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10'b0011_010_0_0_0};
    tab[3]  = '{5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1111_000_0_0_0};
    tab[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1111_000_0_0_0};
    tab[5]  = '{5'd9, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1111_000_0_0_0};
    tab[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 10'b1111_111_0_1_0};
    tab[7]  = '{5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'b1111_111_0_1_0};
    tab[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 10'b1111_000_0_0_1};
    tab[9]  = '{5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 10'b0011_010_0_0_1};
    tab[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 10'b1111_000_0_0_0};
    tab[11] = '{5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 10'b0000_000_1_0_1};
    tab[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'b1111_111_0_1_1};
    tab[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'b1111_000_0_0_0};

    #2;
    chk("reset_ctl", ctl, 10'd0);
    chk("reset_stall", stall_cnt, 16'd0);
    chk("reset_flush", flush_cnt, 16'd0);
    @(posedge clk);
    #1 res = 1'b0;
    model_clear();

    for (int i = 0; i < 14; i++) begin
      set_in(tab[i]);
      cycle();
      chk($sformatf("tab%0d", i), cur_ctl, tab[i].ctl);
    end

    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5;
    cycle();
    chk("lu_ctl", cur_ctl, 10'b0011_010_0_0_0);
    idle();
    cycle();
    chk("lu_stall_cnt", stall_cnt, 16'd1);

    do_reset();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    cycle();
    chk("nohz_ctl", cur_ctl, 10'b1111_000_0_0_0);
    idle();
    cycle();
    chk("nohz_stall_cnt", stall_cnt, 16'd0);

    do_reset();
    mem_read = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wait_ctl", cur_ctl, 10'b0000_000_1_0_1);
    end
    dmem_ready = 1;
    cycle();
    chk("wait_release", cur_ctl, 10'b1111_000_0_0_1);
    idle();
    cycle();
    chk("wait_stall_cnt", stall_cnt, 16'd3);

    do_reset();
    mem_read = 1; mem_branch = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("brwait_ctl", cur_ctl, 10'b0000_000_1_0_1);
    end
    dmem_ready = 1;
    cycle();
    chk("brwait_release", cur_ctl, 10'b1111_111_0_1_1);
    idle();
    cycle();
    chk("brwait_flush_cnt", flush_cnt, 16'd1);
    chk("brwait_no_flush_after", cur_ctl, 10'b1111_000_0_0_0);

    do_reset();
    mem_branch = 1; ex_mem_read = 1; ex_rd = 6; id_rt = 6; id_uses_rt = 1;
    cycle();
    chk("br_lu_ctl", cur_ctl, 10'b1111_111_0_1_0);
    idle();
    cycle();
    chk("br_lu_stall_cnt", stall_cnt, 16'd0);
    chk("br_lu_flush_cnt", flush_cnt, 16'd1);

    do_reset();
    mem_read = 1;
    cycle();
    cycle();
    #2 res = 1'b1;
    #1;
    chk("res_dwait_ctl", ctl, 10'd0);
    chk("res_dwait_stall", stall_cnt, 16'd0);
    @(posedge clk);
    #1 res = 1'b0;
    model_clear();
    idle();
    cycle();
    chk("res_after_ctl", cur_ctl, 10'b1111_000_0_0_0);

    for (int i = 0; i < 3000; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      ex_mem_read = 1'($urandom);
      mem_branch = ($urandom_range(0, 6) == 0);
      mem_read = ($urandom_range(0, 4) == 0);
      mem_write = ($urandom_range(0, 5) == 0);
      dmem_ready = 1'($urandom);
      cycle();
    end

    do_reset();
    mem_read = 1;
    dmem_ready = 0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", stall_cnt, 16'hFFFF);
    @(negedge clk);
    chk("sat_stall_hold", stall_cnt, 16'hFFFF);
    chk("sat_flush", flush_cnt, 16'd0);
    #1 res = 1'b1;
    #1;
    chk("sat_res", stall_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-002 SHALL have port res, input, 1, reset: asynchronous, active-high.
REQ-003 SHALL have ports id_rs and id_rt, input, 5 each, source register indices of the instruction in ID; id_uses_rt, input, 1, set when that instruction reads rt.
REQ-004 SHALL have ports ex_mem_read, input, 1, and ex_rd, input, 5: the ID/EX-stage load flag and its destination register.
REQ-005 SHALL have ports mem_branch, input, 1, a branch resolved taken in MEM (EX/MEM branch AND zero); mem_read and mem_write, input, 1 each, the EX/MEM memory access flags.
REQ-006 SHALL have port dmem_ready, input, 1, data-memory completion for the current request.
REQ-007 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, 1 each: stage-register load enables.
REQ-008 SHALL have outputs ifid_flush, idex_flush, exmem_flush, memwb_bubble, 1 each: zero the control bits entering that register.
REQ-009 SHALL have outputs pc_sel_branch, 1, select the branch target for the PC; dmem_req, 1, data-memory request.
REQ-010 SHALL have outputs stall_cnt and flush_cnt, 16 each: saturating performance counters.

Function
REQ-011 SHALL implement FSM states RUN and DWAIT; control outputs are combinational from state and inputs.
REQ-012 SHALL drive dmem_req = (mem_read OR mem_write) in RUN, and 1 in DWAIT.
REQ-013 SHALL, in RUN with an access and dmem_ready=0, force all four enables to 0, assert memwb_bubble, and go to DWAIT next edge.
REQ-014 SHALL, in DWAIT, keep all enables 0 and memwb_bubble 1 while dmem_ready=0; on dmem_ready=1, release the enables in that same cycle and return to RUN.
REQ-015 SHALL treat an access completed with dmem_ready=1 in the same RUN cycle as zero-wait (no stall).
REQ-016 SHALL ignore dmem_ready when no access is pending.
REQ-017 SHALL, on mem_branch=1 in a non-stalled cycle, assert pc_sel_branch, ifid_flush, idex_flush and exmem_flush for exactly that cycle, with all enables 1.
REQ-018 SHALL hold a mem_branch that arrives during DWAIT (EX/MEM is frozen) and act on it in the cycle dmem_ready=1 arrives.
REQ-019 SHALL detect a load-use hazard when ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs, or id_uses_rt=1 and ex_rd==id_rt).
REQ-020 SHALL, on a load-use hazard, drive pc_en=0, ifid_en=0 and idex_flush=1 for one cycle, with exmem_en=1.
REQ-021 SHALL apply the priority: memory wait > branch flush > load-use; the branch flush suppresses the load-use stall.
REQ-022 SHALL increment stall_cnt once per cycle in which any enable is 0, saturating at 0xFFFF.
REQ-023 SHALL increment flush_cnt once per branch-flush cycle, saturating at 0xFFFF.

Reset
REQ-024 SHALL, while res=1, force the state to RUN, the counters to 0, all enables, flushes, memwb_bubble, pc_sel_branch and dmem_req to 0.
REQ-025 SHALL abandon any DWAIT immediately on res, even mid-access; on release, start in RUN with counters at 0.

Structure
REQ-026 SHALL take the state encoding, register-index width (5) and counter width (16) from a shared package pipe_pkg.
REQ-027 SHALL implement both counters as instances of one sub-module, sat_cnt16 (inputs inc and res; 16-bit saturating output).

Verification
REQ-028 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-029 No hazard: ex_rd=0 with ex_mem_read=1, id_rs=0 -> no stall; stall_cnt stays 0.
REQ-030 Memory wait: mem_read=1, dmem_ready low for 3 cycles -> DWAIT for 3 cycles, enables 0, dmem_req=1; stall_cnt=3.
REQ-031 Branch during wait: mem_branch=1 with dmem_ready low for 2 cycles -> flush pulse only in the ready cycle; flush_cnt=1.
REQ-032 Branch plus load-use in the same cycle -> branch flush only, pc_en=1; stall_cnt unchanged.
REQ-033 res asserted in DWAIT -> immediately RUN, dmem_req=0, counters 0; saturation preload 0xFFFF plus a stall -> stays 0xFFFF.
